krnl_hll_rtl_rd_master: RTL and testbench
=========================================

// Module: krnl_hll_rtl_rd_master
// PURPOSE
// - Kernel datapath front end, directly downstream of the AXI-lite control slave.
// - Consumes ap_start plus a base address and beat count from the control slave, and returns ap_ready/ap_done/ap_idle.
// - Issues AXI4 INCR read bursts on the memory master port and forwards the returned beats as an AXI-stream to the compute core.
// - Keeps one burst outstanding at a time. Bursts never cross a 4 KB boundary.
// PARAMETERS
// - ADDR_W     64   AXI address width
// - DATA_W     512  AXI/stream data width (bytes per beat BPB = DATA_W/8)
// - LEN_W      32   width of the beat-count argument
// - MAX_BURST  64   maximum beats per burst (1..256)
// PORTS
// - aclk           in   1        clock
// - areset         in   1        asynchronous active-high reset
// - ap_start       in   1        start request from the control slave
// - ap_ready       out  1        1-cycle pulse: arguments latched
// - ap_done        out  1        1-cycle pulse: transfer complete
// - ap_idle        out  1        high in IDLE
// - base_addr      in   ADDR_W   start byte address; low log2(BPB) bits are forced to 0
// - num_beats      in   LEN_W    total beats to read
// - m_araddr       out  ADDR_W   AR address
// - m_arlen        out  8        AR length (beats-1)
// - m_arvalid      out  1        AR valid
// - m_arready      in   1        AR ready
// - m_rdata        in   DATA_W   R data
// - m_rlast        in   1        R last
// - m_rvalid       in   1        R valid
// - m_rready       out  1        R ready
// - s_tdata        out  DATA_W   stream data (= m_rdata)
// - s_tvalid       out  1        stream valid
// - s_tready       in   1        stream ready
// - s_tlast        out  1        high on the final beat of the whole transfer
// BEHAVIOUR
// - Reset: async; state=IDLE. m_arvalid, ap_ready, ap_done, s_tvalid, m_rready = 0; ap_idle = 1; addr/remaining regs = 0.
// - FSM states: IDLE, ADDR, DATA, DONE.
// - IDLE: ap_idle=1. On ap_start=1:
//   - latch addr=base_addr (aligned) and rem=num_beats; pulse ap_ready the same cycle.
//   - go to DONE if num_beats==0, else to ADDR.
// - ADDR: m_arvalid=1 with m_araddr=addr and m_arlen=blen-1.
//   - blen = min(rem, MAX_BURST, (4096-addr[11:0])/BPB).
//   - blen, araddr and arlen are registered on entry and held stable while m_arvalid=1.
//   - On m_arvalid & m_arready -> DATA.
// - DATA: combinational pass-through, zero latency, no buffering:
//   - s_tvalid = m_rvalid; m_rready = s_tready.
//   - beat accepted when m_rvalid & s_tready.
//   - s_tlast = m_rvalid & m_rlast & (rem==blen).
//   - On an accepted beat with m_rlast: addr += blen*BPB; rem -= blen.
//     - Next state is DONE if the new rem==0, else ADDR.
//   - m_rlast arriving before blen beats is a slave error; the FSM still closes the burst on m_rlast.
// - DONE: ap_done=1 for exactly one cycle, then IDLE.
// - ap_start is ignored outside IDLE. If ap_start is still high in IDLE after DONE, a new run starts (auto-restart).
// - Address arithmetic is modulo 2^ADDR_W. rem never underflows.
// - Reset asserted mid-burst aborts immediately: outputs take reset values asynchronously; in-flight R beats are dropped.
// - Latency: ap_start to m_arvalid = 1 cycle; final tlast handshake to ap_done = 1 cycle.
// CONFIGURATION
// - Macro KRNL_HLL_RD_PERF_CNT_EN adds output port cycle_cnt [31:0]:
//   - cleared on the ap_ready cycle; increments every cycle while not IDLE; saturates at 0xFFFFFFFF;
//   - holds its value after ap_done until the next start. Reset value 0.
// - Without the macro, the port and counter are absent and behaviour is otherwise identical.
// TESTING
// - base 0x1000, n=4, tready=1 -> araddr 0x1000, arlen 3; 4 stream beats, tlast on beat 4; ap_done 1 cycle later.
// - base 0x0, n=130 -> ARs (0x0,63), (0x1000,63), (0x2000,1); tlast only on beat 130.
// - base 0x0FC0, n=4 -> 4 KB split: (0x0FC0, arlen 0), then (0x1000, arlen 2).
// - n=0 -> ap_ready pulse, ap_done next cycle, no arvalid ever.
// - n=8, random tready/rvalid stalls -> m_rready tracks s_tready every cycle; all 8 beats delivered in order; none lost or duplicated.
// - areset pulsed mid-DATA -> arvalid/tvalid/rready go 0 at once, ap_idle=1; a fresh run (n=2) then completes normally.

Source files
------------

// File: rtl/krnl_hll_rtl_rd_master.sv
// krnl_hll_rtl_rd_master: AXI4 read master feeding an AXI-stream.
// Takes ap_start/base/count from the control slave. Issues one INCR burst
// at a time, never crossing a 4 KB page. Forwards R beats to the stream
// with zero latency.
// Optional feature macro: KRNL_HLL_RD_PERF_CNT_EN adds the cycle_cnt port.
module krnl_hll_rtl_rd_master #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int LEN_W     = 32,
  parameter int MAX_BURST = 64
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_beats,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [DATA_W-1:0] s_tdata,
  output logic              s_tvalid,
  input  logic              s_tready,
  output logic              s_tlast
`ifdef KRNL_HLL_RD_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);

  localparam int BPB   = DATA_W / 8;
  localparam int OFF_W = $clog2(BPB);
  localparam int CMPW  = (LEN_W > 13) ? LEN_W : 13;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [8:0]        blen_q, blen_d;
  logic [ADDR_W-1:0] base_aligned;

  // Beats in the next burst: limited by remaining count, MAX_BURST and the
  // distance to the next 4 KB page boundary.
  function automatic logic [8:0] calc_blen(input logic [11:0] a_lo,
                                           input logic [LEN_W-1:0] r);
    logic [12:0]     page;
    logic [CMPW-1:0] cap;
    logic [CMPW-1:0] rx;
    page = (13'd4096 - {1'b0, a_lo}) >> OFF_W;
    cap  = CMPW'(page);
    if (cap > CMPW'(MAX_BURST)) cap = CMPW'(MAX_BURST);
    rx = CMPW'(r);
    if (rx < cap) cap = rx;
    return 9'(cap);
  endfunction

  assign base_aligned = {base_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign m_araddr     = addr_q;
  assign m_arlen      = 8'(blen_q - 9'd1);
  assign s_tdata      = m_rdata;

  // Next-state, argument/burst bookkeeping and handshake outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    blen_d    = blen_q;
    ap_ready  = 1'b0;
    ap_done   = 1'b0;
    ap_idle   = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start && !areset) begin
          ap_ready = 1'b1;
          addr_d   = base_aligned;
          rem_d    = num_beats;
          if (num_beats == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ADDR;
            blen_d  = calc_blen(base_aligned[11:0], num_beats);
          end
        end
      end
      S_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = S_DATA;
      end
      S_DATA: begin
        s_tvalid = m_rvalid;
        m_rready = s_tready;
        s_tlast  = m_rvalid & m_rlast & (rem_q == LEN_W'(blen_q));
        // The burst closes on rlast even if it arrives early (slave error).
        if (m_rvalid && s_tready && m_rlast) begin
          addr_d = addr_q + (ADDR_W'(blen_q) << OFF_W);
          rem_d  = (rem_q >= LEN_W'(blen_q)) ? rem_q - LEN_W'(blen_q) : '0;
          if (rem_d == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ADDR;
            blen_d  = calc_blen(addr_d[11:0], rem_d);
          end
        end
      end
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and burst registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
    end
  end

`ifdef KRNL_HLL_RD_PERF_CNT_EN
  logic [31:0] cnt_q;

  // Busy-cycle counter: cleared at start, saturating, held while idle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else if (ap_ready) begin
      cnt_q <= '0;
    end else if (state_q != S_IDLE && cnt_q != '1) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_krnl_hll_rtl_rd_master.sv
// tb_krnl_hll_rtl_rd_master: randomized bench with an AXI slave responder
// and a run-level reference model of bursts and stream beats.
module tb_krnl_hll_rtl_rd_master;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 512;
  localparam int LEN_W     = 32;
  localparam int MAX_BURST = 64;
  localparam int BPB       = DATA_W / 8;

  logic              aclk, areset, ap_start, ap_ready, ap_done, ap_idle;
  logic [ADDR_W-1:0] base_addr, m_araddr;
  logic [LEN_W-1:0]  num_beats;
  logic [7:0]        m_arlen;
  logic              m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [DATA_W-1:0] m_rdata, s_tdata;
  logic              s_tvalid, s_tready, s_tlast;
`ifdef KRNL_HLL_RD_PERF_CNT_EN
  logic [31:0]       cycle_cnt;
`endif

  krnl_hll_rtl_rd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
  ) dut (
`ifdef KRNL_HLL_RD_PERF_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .base_addr(base_addr),
    .num_beats(num_beats), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference plan: walk the transfer, cutting at MAX_BURST and 4 KB pages.
  function automatic int nburst(input logic [63:0] base, input logic [31:0] n);
    logic [63:0] a;
    longint unsigned r, pg, b;
    int k;
    a = base & ~64'(BPB - 1);
    r = n;
    k = 0;
    while (r > 0) begin
      pg = (4096 - (a % 4096)) / BPB;
      b = r;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > pg) b = pg;
      a = a + b * BPB;
      r = r - b;
      k++;
    end
    return k;
  endfunction

  // {address, arlen} of burst number k of the transfer.
  function automatic logic [71:0] kth_burst(input logic [63:0] base,
                                            input logic [31:0] n, input int k);
    logic [63:0] a;
    longint unsigned r, pg, b;
    a = base & ~64'(BPB - 1);
    r = n;
    for (int i = 0; i <= k && r > 0; i++) begin
      pg = (4096 - (a % 4096)) / BPB;
      b = r;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > pg) b = pg;
      if (i == k) return {a, 8'(b - 1)};
      a = a + b * BPB;
      r = r - b;
    end
    return '1;
  endfunction

  function automatic logic [DATA_W-1:0] pat(input logic [63:0] a);
    return {8{a ^ 64'hA5A5_0000_0000_0000}};
  endfunction

  // Model state
  bit          busy, done_next, data_active, stall;
  logic [63:0] run_base, r_addr;
  logic [31:0] run_n;
  int          run_idx, run_left, beats_seen, tlast_seen, r_left;
  int          runs_started, runs_done;
  logic [31:0] exp_cnt;

  // Slave responder plus per-cycle compare against the model.
  initial begin
    int nb;
    logic [71:0] kb;
    bit st_hs, ar_hs, r_hs, was_done, was_busy, rl, tl;
    logic [63:0] sb, sa;
    logic [31:0] sn;
    logic [7:0]  sl;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
    s_tready = 1'b0;
    busy = 0; done_next = 0; data_active = 0; r_left = 0; exp_cnt = '0;
    runs_started = 0; runs_done = 0; run_idx = 0; run_left = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_tvalid", s_tvalid, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_idle", ap_idle, 1);
        chk("rst_ready", ap_ready, 0);
        chk("rst_done", ap_done, 0);
`ifdef KRNL_HLL_RD_PERF_CNT_EN
        chk("rst_cnt", cycle_cnt, 0);
`endif
        busy = 0; done_next = 0; data_active = 0; r_left = 0; exp_cnt = '0;
        @(posedge aclk); #1;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
        continue;
      end
      nb = busy ? nburst(run_base, run_n) : 0;
      chk("ap_idle", ap_idle, !busy);
      chk("ap_ready", ap_ready, ap_start && !busy);
      chk("ap_done", ap_done, done_next);
      chk("m_arvalid", m_arvalid, busy && !done_next && !data_active && run_idx < nb);
      if (m_arvalid && busy && run_idx < nb) begin
        kb = kth_burst(run_base, run_n, run_idx);
        chk("m_araddr", m_araddr, kb[71:8]);
        chk("m_arlen", m_arlen, kb[7:0]);
      end
      chk("s_tvalid", s_tvalid, data_active && m_rvalid);
      chk("m_rready", m_rready, data_active && s_tready);
      if (s_tvalid) begin
        chk("s_tdata_pass", s_tdata, m_rdata);
        chk("s_tlast", s_tlast, m_rlast && run_left == 1);
      end
      if (s_tvalid && s_tready)
        chk("beat_data", s_tdata,
            pat((run_base & ~64'(BPB - 1)) + 64'(beats_seen) * BPB));
`ifdef KRNL_HLL_RD_PERF_CNT_EN
      chk("cycle_cnt", cycle_cnt, exp_cnt);
`endif
      st_hs = ap_ready; ar_hs = m_arvalid && m_arready;
      r_hs = m_rvalid && m_rready; was_done = done_next; was_busy = busy;
      rl = m_rlast; tl = s_tlast; sb = base_addr; sn = num_beats;
      sa = m_araddr; sl = m_arlen;
      @(posedge aclk); #1;
      if (was_busy && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
      if (was_done) begin
        busy = 0; done_next = 0; runs_done++;
        chk("run_beats", beats_seen, run_n);
        chk("run_tlasts", tlast_seen, run_n != 0);
      end
      if (st_hs) begin
        busy = 1; run_base = sb; run_n = sn; run_idx = 0; beats_seen = 0;
        tlast_seen = 0; run_left = sn; exp_cnt = '0; runs_started++;
        if (sn == 0) done_next = 1;
      end
      if (ar_hs) begin
        data_active = 1; r_addr = sa; r_left = int'(sl) + 1; run_idx++;
      end
      if (r_hs) begin
        beats_seen++; run_left--; r_left--; r_addr = r_addr + BPB;
        if (tl) tlast_seen++;
        if (rl) begin
          data_active = 0;
          if (run_left == 0) done_next = 1;
        end
      end
      m_arready = stall ? 1'($urandom % 2) : 1'b1;
      if (!(m_rvalid && !r_hs)) begin
        if (data_active && r_left > 0 && (!stall || ($urandom % 3) != 0)) begin
          m_rvalid = 1'b1; m_rdata = pat(r_addr); m_rlast = (r_left == 1);
        end else begin
          m_rvalid = 1'b0; m_rlast = 1'b0;
        end
      end
      s_tready = stall ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic run(input logic [63:0] b, input logic [31:0] n,
                     input bit st, input int starts);
    int s0;
    @(posedge aclk); #2;
    s0 = runs_started;
    stall = st; base_addr = b; num_beats = n; ap_start = 1'b1;
    for (int i = 0; i < 400 && runs_started < s0 + starts; i++) begin
      @(posedge aclk); #2;
    end
    ap_start = 1'b0;
    chk("start_timeout", runs_started >= s0 + starts, 1);
    for (int i = 0; i < 20000 && busy; i++) begin
      @(posedge aclk); #2;
    end
    chk("done_timeout", busy, 0);
  endtask

  // Test sequence
  initial begin
    int d0;
    areset = 1'b1; ap_start = 1'b0; base_addr = '0; num_beats = '0; stall = 0;
    // Pin the reference plan against hand-worked values.
    chk("pin_a_cnt", nburst(64'h1000, 4), 1);
    chk("pin_a_b0", kth_burst(64'h1000, 4, 0), {64'h1000, 8'd3});
    chk("pin_b_cnt", nburst(64'h0, 130), 3);
    chk("pin_b_b0", kth_burst(64'h0, 130, 0), {64'h0, 8'd63});
    chk("pin_b_b1", kth_burst(64'h0, 130, 1), {64'h1000, 8'd63});
    chk("pin_b_b2", kth_burst(64'h0, 130, 2), {64'h2000, 8'd1});
    chk("pin_c_b0", kth_burst(64'h0FC0, 4, 0), {64'h0FC0, 8'd0});
    chk("pin_c_b1", kth_burst(64'h0FC0, 4, 1), {64'h1000, 8'd2});
    chk("pin_zero", nburst(64'h123, 0), 0);
    chk("pin_align", kth_burst(64'h1023, 1, 0), {64'h1000, 8'd0});
    repeat (3) @(posedge aclk);
    #3 areset = 1'b0;

    run(64'h1000, 4, 0, 1);
    run(64'h0, 130, 0, 1);
    run(64'h0FC0, 4, 0, 1);
    run(64'h123, 0, 0, 1);
    run(64'h40_0000, 8, 1, 1);
    chk("runs_done_5", runs_done, 5);
    d0 = runs_done;
    run(64'h7F80, 3, 1, 2);
    chk("auto_restart", runs_done - d0, 2);
    for (int i = 0; i < 6; i++)
      run({32'($urandom), 32'($urandom)}, 32'($urandom_range(1, 150)), 1, 1);

    // Reset in the middle of a data phase.
    @(posedge aclk); #2;
    stall = 1; base_addr = 64'h0; num_beats = 100; ap_start = 1'b1;
    d0 = runs_started;
    for (int i = 0; i < 400 && runs_started == d0; i++) begin
      @(posedge aclk); #2;
    end
    ap_start = 1'b0;
    for (int i = 0; i < 2000 && !(data_active && beats_seen >= 3); i++) begin
      @(posedge aclk); #2;
    end
    chk("mid_data_reached", data_active && beats_seen >= 3, 1);
    @(posedge aclk); #3;
    areset = 1'b1;
    #1;
    chk("async_arvalid", m_arvalid, 0);
    chk("async_tvalid", s_tvalid, 0);
    chk("async_rready", m_rready, 0);
    chk("async_idle", ap_idle, 1);
    @(posedge aclk); @(posedge aclk); #3;
    areset = 1'b0;
    d0 = runs_done;
    run(64'h2000, 2, 0, 1);
    chk("post_reset_run", runs_done - d0, 1);

    repeat (3) @(posedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
